div_seq: RTL and testbench

- Multi-cycle sequential signed/unsigned integer divider with valid/ready handshakes on both sides.
- Retires one quotient bit per clock using restoring shift-subtract. It replaces the wide combinational divide array wherever timing or area forbids a single-cycle divider.
- Sits between an execute-stage issue port and the writeback path. Holds at most one operation in flight.

---
 rtl/div_seq_if.sv | 25 ++
 rtl/div_seq.sv | 152 +++++++++++++++
 tb/tb_div_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Issue/writeback handshake bundle for the sequential divider.
interface div_seq_if #(
    parameter int n = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         sign;
    logic         out_valid;
    logic         out_ready;
    logic [n-1:0] quot;
    logic [n-1:0] rem;
    logic         div_zero;

    modport master (
        output in_valid, a, b, sign, out_ready,
        input  in_ready, out_valid, quot, rem, div_zero
    );

    modport slave (
        input  in_valid, a, b, sign, out_ready,
        output in_ready, out_valid, quot, rem, div_zero
    );
endinterface

// File: rtl/div_seq.sv
// Restoring shift-subtract divider, one quotient bit per clock, signed or unsigned.
// state | meaning
// IDLE  | ready for operands
// PREP  | take magnitudes, latch result signs, detect zero divisor
// ITER  | n shift-subtract steps, MSB first
// FIX   | apply signs (or zero-divisor result) and load outputs
// DONE  | result presented until consumed
module div_seq #(
    parameter int n = 32
) (
    input  logic     i_clk,
    input  logic     i_reset,
    input  logic     i_flush,
    div_seq_if.slave s_if
);
    localparam int cw = $clog2(n + 1);
    localparam logic [cw-1:0] LP_LAST = cw'(n - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_in_ready;
    logic          w_out_valid;

    logic [n-1:0]  r_a;
    logic [n-1:0]  r_b;
    logic          r_sign;
    logic [n-1:0]  r_dvd;
    logic [n-1:0]  r_bv;
    logic [n-1:0]  r_pr;
    logic [cw-1:0] r_cnt;
    logic          r_qs;
    logic          r_rs;
    logic          r_dz;
    logic [n-1:0]  r_quot;
    logic [n-1:0]  r_rem;
    logic          r_div_zero;

    logic          w_as;
    logic          w_bs;
    logic [n-1:0]  w_av;
    logic [n-1:0]  w_bv;
    logic [n:0]    w_pr_sh;
    logic [n:0]    w_trial;

    assign w_as    = r_sign & r_a[n-1];
    assign w_bs    = r_sign & r_b[n-1];
    assign w_av    = w_as ? -r_a : r_a;
    assign w_bv    = w_bs ? -r_b : r_b;
    // The partial remainder is always below the divisor, so n bits hold it; the trial needs n+1.
    assign w_pr_sh = {r_pr, r_dvd[n-1]};
    assign w_trial = w_pr_sh - {1'b0, r_bv};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (s_if.in_valid) w_next = ST_PREP;
            end
            // A zero divisor also passes through FIX so its result lands one cycle after PREP.
            ST_PREP: w_next = (r_b == '0) ? ST_FIX : ST_ITER;
            ST_ITER: if (r_cnt == LP_LAST) w_next = ST_FIX;
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (s_if.out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (i_flush) w_next = ST_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sign     <= 1'b0;
            r_dvd      <= '0;
            r_bv       <= '0;
            r_pr       <= '0;
            r_cnt      <= '0;
            r_qs       <= 1'b0;
            r_rs       <= 1'b0;
            r_dz       <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_if.in_valid) begin
                        r_a    <= s_if.a;
                        r_b    <= s_if.b;
                        r_sign <= s_if.sign;
                    end
                end
                ST_PREP: begin
                    r_dvd <= w_av;
                    r_bv  <= w_bv;
                    r_qs  <= w_as ^ w_bs;
                    r_rs  <= w_as;
                    r_pr  <= '0;
                    r_cnt <= '0;
                    r_dz  <= (r_b == '0);
                end
                ST_ITER: begin
                    r_cnt <= r_cnt + cw'(1);
                    r_pr  <= w_trial[n] ? w_pr_sh[n-1:0] : w_trial[n-1:0];
                    r_dvd <= {r_dvd[n-2:0], ~w_trial[n]};
                end
                ST_FIX: begin
                    if (!i_flush) begin
                        if (r_dz) begin
                            r_quot     <= '1;
                            r_rem      <= r_a;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_quot     <= r_qs ? -r_dvd : r_dvd;
                            r_rem      <= r_rs ? -r_pr : r_pr;
                            r_div_zero <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_if.in_ready  = w_in_ready;
    assign s_if.out_valid = w_out_valid;
    assign s_if.quot      = r_quot;
    assign s_if.rem       = r_rem;
    assign s_if.div_zero  = r_div_zero;
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq at n=8: directed corners, randomized ops, backpressure, flush and reset.
module tb_div_seq;
    localparam int N = 8;

    logic clk;
    logic rst;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    div_seq_if #(.n(N)) bus ();

    div_seq #(.n(N)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_flush (flush),
        .s_if    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    // Truncating division: quotient rounds toward zero, remainder carries the dividend's sign.
    function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                                    output logic [N-1:0] q, output logic [N-1:0] r, output logic dz);
        int sa;
        int sb;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = N'(sa / sb);
            r  = N'(sa % sb);
            dz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    // Presents one operation, returns edges from accept to out_valid and whether in_ready stayed low.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                         output int lat, output logic busy_ok);
        int g;
        g = 0;
        while (bus.in_ready !== 1'b1 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        bus.a        = a;
        bus.b        = b;
        bus.sign     = s;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = N'($urandom);
        bus.b        = N'($urandom);
        bus.sign     = 1'($urandom_range(1));
        lat     = 0;
        busy_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic finish_op;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.sign = 1'b0;
        #12;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.quot !== 8'h00) begin errors++; $display("FAIL reset_quot: got %h expected 00", bus.quot); end
        checks++; if (bus.rem !== 8'h00) begin errors++; $display("FAIL reset_rem: got %h expected 00", bus.rem); end
        checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b expected 0", bus.div_zero); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [N-1:0] ta [6] = '{8'd100, 8'hF9, 8'h07, 8'h5A, 8'h80, 8'h80};
        logic [N-1:0] tb [6] = '{8'd7,   8'h02, 8'hFE, 8'h00, 8'hFF, 8'hFF};
        logic         ts [6] = '{1'b0,   1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
        logic [N-1:0] eq [6] = '{8'd14,  8'hFD, 8'hFD, 8'hFF, 8'h80, 8'h00};
        logic [N-1:0] er [6] = '{8'd2,   8'hFF, 8'h01, 8'h5A, 8'h00, 8'h80};
        logic         ez [6] = '{1'b0,   1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
        int           el [6] = '{10, 10, 10, 2, 10, 10};
        int           lat;
        logic         busy;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], ts[i], lat, busy);
            checks++; if (bus.quot !== eq[i]) begin errors++; $display("FAIL directed%0d_quot: got %h expected %h", i, bus.quot, eq[i]); end
            checks++; if (bus.rem !== er[i]) begin errors++; $display("FAIL directed%0d_rem: got %h expected %h", i, bus.rem, er[i]); end
            checks++; if (bus.div_zero !== ez[i]) begin errors++; $display("FAIL directed%0d_div_zero: got %b expected %b", i, bus.div_zero, ez[i]); end
            checks++; if (lat !== el[i]) begin errors++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, el[i]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL directed%0d_in_ready_low: got %b expected 1", i, busy); end
            finish_op();
        end
    endtask

    task automatic test_random;
        logic [N-1:0] a, b, q, r;
        logic         s, dz;
        int           lat;
        logic         busy;
        for (int i = 0; i < 60; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            s = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) b = '0;
            if ($urandom_range(9) == 0) begin a = 8'h80; b = 8'hFF; end
            ref_div(a, b, s, q, r, dz);
            do_op(a, b, s, lat, busy);
            checks++; if (bus.quot !== q) begin errors++; $display("FAIL random%0d_quot: a=%h b=%h s=%b got %h expected %h", i, a, b, s, bus.quot, q); end
            checks++; if (bus.rem !== r) begin errors++; $display("FAIL random%0d_rem: a=%h b=%h s=%b got %h expected %h", i, a, b, s, bus.rem, r); end
            checks++; if (bus.div_zero !== dz) begin errors++; $display("FAIL random%0d_div_zero: got %b expected %b", i, bus.div_zero, dz); end
            checks++; if (lat !== (dz ? 2 : N + 2)) begin errors++; $display("FAIL random%0d_latency: got %0d expected %0d", i, lat, dz ? 2 : N + 2); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL random%0d_in_ready_low: got %b expected 1", i, busy); end
            repeat ($urandom_range(2)) begin @(posedge clk); #1; end
            finish_op();
        end
    endtask

    task automatic test_backpressure;
        int   lat;
        logic busy;
        logic stable;
        do_op(8'd200, 8'd9, 1'b0, lat, busy);
        bus.a = 8'd50; bus.b = 8'd5; bus.sign = 1'b0; bus.in_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.quot !== 8'd22 || bus.rem !== 8'd2 || bus.in_ready !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (stable !== 1'b1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got stable=%b q=%h r=%h expected stable=1 q=16 r=02", stable, bus.quot, bus.rem); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept: got in_ready=%b expected 0", bus.in_ready); end
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== N + 2) begin errors++; $display("FAIL bp_next_latency: got %0d expected %0d", lat, N + 2); end
        checks++; if (bus.quot !== 8'd10 || bus.rem !== 8'd0) begin errors++; $display("FAIL bp_next_result: got %h/%h expected 0a/00", bus.quot, bus.rem); end
        finish_op();
    endtask

    task automatic test_flush_reset;
        int   lat;
        logic busy;
        logic quiet;
        // flush on the third ITER cycle
        bus.a = 8'd100; bus.b = 8'd7; bus.sign = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_iter_state: got ov=%b ir=%b expected ov=0 ir=1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.quot !== 8'd10 || bus.rem !== 8'd0) begin errors++; $display("FAIL flush_iter_hold: got %h/%h expected 0a/00", bus.quot, bus.rem); end
        quiet = 1'b1;
        repeat (15) begin @(posedge clk); #1; if (bus.out_valid !== 1'b0) quiet = 1'b0; end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL flush_iter_no_result: got %b expected 1", quiet); end

        // flush in IDLE together with in_valid drops the op
        bus.a = 8'd33; bus.b = 8'd3; bus.in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_in_ready: got %b expected 1", bus.in_ready); end
        quiet = 1'b1;
        repeat (15) begin @(posedge clk); #1; if (bus.out_valid !== 1'b0) quiet = 1'b0; end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL flush_idle_no_result: got %b expected 1", quiet); end

        // asynchronous reset in the middle of ITER
        bus.a = 8'd77; bus.b = 8'd5; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_async_state: got ir=%b ov=%b expected ir=1 ov=0", bus.in_ready, bus.out_valid); end
        checks++; if (bus.quot !== 8'd0 || bus.rem !== 8'd0) begin errors++; $display("FAIL reset_async_result: got %h/%h expected 00/00", bus.quot, bus.rem); end
        #2;
        rst = 1'b0;
        quiet = 1'b1;
        repeat (15) begin @(posedge clk); #1; if (bus.out_valid !== 1'b0) quiet = 1'b0; end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL reset_no_result: got %b expected 1", quiet); end

        do_op(8'd100, 8'd7, 1'b0, lat, busy);
        checks++; if (bus.quot !== 8'd14 || bus.rem !== 8'd2 || bus.div_zero !== 1'b0) begin errors++; $display("FAIL after_abort_result: got %h/%h/%b expected 0e/02/0", bus.quot, bus.rem, bus.div_zero); end
        checks++; if (lat !== N + 2) begin errors++; $display("FAIL after_abort_latency: got %0d expected %0d", lat, N + 2); end

        // flush in DONE discards the unread result but keeps the registers
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_done_state: got ov=%b ir=%b expected ov=0 ir=1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.quot !== 8'd14 || bus.rem !== 8'd2) begin errors++; $display("FAIL flush_done_hold: got %h/%h expected 0e/02", bus.quot, bus.rem); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
